index_addr_seq: RTL

INDEX_ADDR_SEQ -- requirements
Module: index_addr_seq

---
 rtl/control_signals.sv | 37 +++
 rtl/alu.sv | 72 +++++++
 rtl/index_addr_seq.sv | 129 ++++++++++++
 3 files changed

// File: rtl/control_signals.sv
// Shared control encodings for the datapath.
// Holds the alu opcode set and the index address sequencer states.
package control_signals;

   localparam int BYTE_W  = 8;
   localparam int ADDR_W  = 16;
   localparam int INDEX_W = 8;

   typedef enum logic [3:0] {
      ALU_ADD    = 4'd0,
      ALU_SUB    = 4'd1,
      ALU_AND    = 4'd2,
      ALU_OR     = 4'd3,
      ALU_XOR    = 4'd4,
      ALU_SHL    = 4'd5,
      ALU_SHR    = 4'd6,
      ALU_ROL    = 4'd7,
      ALU_ROR    = 4'd8,
      ALU_PASS_A = 4'd9,
      ALU_PASS_B = 4'd10,
      ALU_INC    = 4'd11,
      ALU_DEC    = 4'd12
   } alu_op_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ADD_LO = 2'd1,
      ADD_HI = 2'd2,
      DONE   = 2'd3
   } addr_seq_state_t;

   // True for the states in which a sequence is actively using the alu.
   function automatic logic seq_active(input addr_seq_state_t s);
      return (s == ADD_LO) || (s == ADD_HI);
   endfunction

endpackage

// File: rtl/alu.sv
// Shared 8-bit alu used by the datapath.
// Purely combinational; the parent datapath owns the only instance.
module alu
   import control_signals::*;
(
   input  alu_op_t             alu_op,
   input  logic                carry_in,
   input  logic [BYTE_W-1:0]   a,
   input  logic [BYTE_W-1:0]   b,
   output logic [BYTE_W-1:0]   alu_out,
   output logic                carry_out
);

   logic [BYTE_W:0] sum;
   logic [BYTE_W:0] diff;

   // Adder and borrow-style subtractor (a + ~b + carry_in).
   always_comb begin
      sum  = {1'b0, a} + {1'b0, b} + {{BYTE_W{1'b0}}, carry_in};
      diff = {1'b0, a} + {1'b0, ~b} + {{BYTE_W{1'b0}}, carry_in};
   end

   // Result and carry selection by opcode.
   always_comb begin
      alu_out   = '0;
      carry_out = 1'b0;
      unique case (alu_op)
         ALU_ADD: begin
            alu_out   = sum[BYTE_W-1:0];
            carry_out = sum[BYTE_W];
         end
         ALU_SUB: begin
            alu_out   = diff[BYTE_W-1:0];
            carry_out = diff[BYTE_W];
         end
         ALU_AND: alu_out = a & b;
         ALU_OR:  alu_out = a | b;
         ALU_XOR: alu_out = a ^ b;
         ALU_SHL: begin
            alu_out   = {a[BYTE_W-2:0], 1'b0};
            carry_out = a[BYTE_W-1];
         end
         ALU_SHR: begin
            alu_out   = {1'b0, a[BYTE_W-1:1]};
            carry_out = a[0];
         end
         ALU_ROL: begin
            alu_out   = {a[BYTE_W-2:0], carry_in};
            carry_out = a[BYTE_W-1];
         end
         ALU_ROR: begin
            alu_out   = {carry_in, a[BYTE_W-1:1]};
            carry_out = a[0];
         end
         ALU_PASS_A: alu_out = a;
         ALU_PASS_B: alu_out = b;
         ALU_INC: begin
            alu_out   = a + 8'h01;
            carry_out = (a == 8'hFF);
         end
         ALU_DEC: begin
            alu_out   = a - 8'h01;
            carry_out = (a != 8'h00);
         end
         default: begin
            alu_out   = '0;
            carry_out = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/index_addr_seq.sv
// Indexed effective-address sequencer: base + index via the shared alu.
// Low byte first; high byte only on page cross or when forced.
module index_addr_seq
   import control_signals::*;
#(
   parameter bit FORCE_HIGH_CYCLE = 1'b0
)
(
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [INDEX_W-1:0]  index,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   eff_addr,
   output logic                page_cross,
   output alu_op_t             alu_operation,
   output logic                alu_carry_in,
   output logic [BYTE_W-1:0]   alu_input_a,
   output logic [BYTE_W-1:0]   alu_input_b,
   input  logic [BYTE_W-1:0]   alu_result,
   input  logic                alu_carry
);

   addr_seq_state_t      state_q;
   addr_seq_state_t      state_d;

   logic [ADDR_W-1:0]    base_q;
   logic [INDEX_W-1:0]   index_q;
   logic [ADDR_W-1:0]    eff_addr_q;
   logic                 page_cross_q;

   logic                 load_ops;
   logic                 load_lo;
   logic                 copy_hi;
   logic                 load_hi;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next state, alu drive and register enables; outputs use state only.
   always_comb begin
      state_d       = state_q;
      load_ops      = 1'b0;
      load_lo       = 1'b0;
      copy_hi       = 1'b0;
      load_hi       = 1'b0;
      alu_operation = ALU_ADD;
      alu_carry_in  = 1'b0;
      alu_input_a   = '0;
      alu_input_b   = '0;
      done          = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               load_ops = 1'b1;
               state_d  = ADD_LO;
            end
         end
         ADD_LO: begin
            alu_input_a = base_q[BYTE_W-1:0];
            alu_input_b = index_q;
            load_lo     = 1'b1;
            if (alu_carry || FORCE_HIGH_CYCLE) begin
               state_d = ADD_HI;
            end else begin
               copy_hi = 1'b1;
               state_d = DONE;
            end
         end
         ADD_HI: begin
            alu_input_a  = base_q[ADDR_W-1:BYTE_W];
            alu_input_b  = 8'h00;
            alu_carry_in = page_cross_q;
            load_hi      = 1'b1;
            state_d      = DONE;
         end
         DONE: begin
            done = 1'b1;
            if (start) begin
               load_ops = 1'b1;
               state_d  = ADD_LO;
            end else begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Operand latch and result registers; the final high-byte carry is dropped.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_q       <= '0;
         index_q      <= '0;
         eff_addr_q   <= '0;
         page_cross_q <= 1'b0;
      end else begin
         if (load_ops) begin
            base_q  <= base_addr;
            index_q <= index;
         end
         if (load_lo) begin
            eff_addr_q[BYTE_W-1:0] <= alu_result;
            page_cross_q           <= alu_carry;
         end
         if (copy_hi) begin
            eff_addr_q[ADDR_W-1:BYTE_W] <= base_q[ADDR_W-1:BYTE_W];
         end
         if (load_hi) begin
            eff_addr_q[ADDR_W-1:BYTE_W] <= alu_result;
         end
      end
   end

   assign busy       = seq_active(state_q);
   assign eff_addr   = eff_addr_q;
   assign page_cross = page_cross_q;

endmodule
